// File: rtl/mega_jsoc_onchip_mem_2p.sv
// Dual Avalon-MM slave RAM: two ports share one single-port array through a round-robin
// arbiter, with byte-enabled writes and in-order pipelined reads of latency 1 + OUTPUT_REG.
module mega_jsoc_onchip_mem_2p #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 15,
  parameter int    DEPTH      = 32768,
  parameter int    OUTPUT_REG = 0,
  parameter string INIT_FILE  = "Mega_JSoC_onchip_mem_2p.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic                    s1_waitrequest,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic                    s2_waitrequest,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {PORT_S1 = 1'b0, PORT_S2 = 1'b1} port_e;
  typedef struct packed {
    logic  valid;
    port_e port;
    logic  oor;
  } tag_t;

  logic en, req1, req2, gnt1, gnt2;
  port_e last_grant_q, last_grant_d;

  assign en   = clken & ~reset_req & ~reset;
  assign req1 = s1_chipselect & (s1_read | s1_write);
  assign req2 = s2_chipselect & (s2_read | s2_write);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    gnt1 = 1'b0;
    gnt2 = 1'b0;
    if (en) begin
      if (req1 && req2) begin
        gnt1 = (last_grant_q == PORT_S2);
        gnt2 = ~gnt1;
      end else begin
        gnt1 = req1;
        gnt2 = req2;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt1)      last_grant_d = PORT_S1;
    else if (gnt2) last_grant_d = PORT_S2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant_q <= PORT_S2;
    else       last_grant_q <= last_grant_d;
  end

  assign s1_waitrequest = req1 & ~gnt1;
  assign s2_waitrequest = req2 & ~gnt2;

  // Granted access, muxed onto the single memory port.
  port_e                 acc_port;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [NB-1:0]         acc_be;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_wr, acc_rd, acc_in_range;
  logic [IW-1:0]         acc_idx;

  always_comb begin
    acc_port  = gnt2 ? PORT_S2 : PORT_S1;
    acc_addr  = gnt2 ? s2_address : s1_address;
    acc_be    = gnt2 ? s2_byteenable : s1_byteenable;
    acc_wdata = gnt2 ? s2_writedata : s1_writedata;
    acc_wr    = gnt2 ? s2_write : (gnt1 & s1_write);
    acc_rd    = (gnt1 | gnt2) & ~acc_wr;
  end

  assign acc_in_range = 32'(acc_addr) < DEPTH;
  assign acc_idx      = acc_addr[IW-1:0];

  (* ram_init_file = INIT_FILE *)
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // NOTE: the array and its read register have no reset so they map onto block RAM;
  // memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (acc_wr && acc_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (acc_be[b]) mem_q[acc_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
      end
    end
    if (acc_rd) rd_data_q <= mem_q[acc_idx];
  end

  tag_t                  launch_tag, tag1_q, out_tag;
  logic [DATA_WIDTH-1:0] out_data;

  assign launch_tag = '{valid: acc_rd, port: acc_port, oor: ~acc_in_range};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      tag1_q <= '0;
    else if (clken) tag1_q <= launch_tag;
  end

  if (OUTPUT_REG != 0) begin : g_out_reg
    tag_t                  tag2_q;
    logic [DATA_WIDTH-1:0] data2_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        tag2_q  <= '0;
        data2_q <= '0;
      end else if (clken) begin
        tag2_q  <= tag1_q;
        data2_q <= rd_data_q;
      end
    end

    assign out_tag  = tag2_q;
    assign out_data = data2_q;
  end else begin : g_no_out_reg
    assign out_tag  = tag1_q;
    assign out_data = rd_data_q;
  end

  // A result is only presented on enabled cycles; otherwise the final stage simply holds it.
  logic                  deliver1, deliver2;
  logic [DATA_WIDTH-1:0] deliver_data, s1_hold_q, s2_hold_q;

  assign deliver1     = clken & out_tag.valid & (out_tag.port == PORT_S1);
  assign deliver2     = clken & out_tag.valid & (out_tag.port == PORT_S2);
  assign deliver_data = out_tag.oor ? '0 : out_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_hold_q <= '0;
      s2_hold_q <= '0;
    end else begin
      if (deliver1) s1_hold_q <= deliver_data;
      if (deliver2) s2_hold_q <= deliver_data;
    end
  end

  assign s1_readdatavalid = deliver1;
  assign s2_readdatavalid = deliver2;
  assign s1_readdata      = deliver1 ? deliver_data : s1_hold_q;
  assign s2_readdata      = deliver2 ? deliver_data : s2_hold_q;

endmodule

// File: tb/tb_mega_jsoc_onchip_mem_2p.sv
// Bench for mega_jsoc_onchip_mem_2p: two instances (OUTPUT_REG 0 and 1, DEPTH 1000) share
// the same stimulus and are compared every cycle against a transaction-level model.
module tb_mega_jsoc_onchip_mem_2p;

  localparam int DEPTH = 1000;

  logic        clk, reset, clken, reset_req;
  logic [9:0]  s1_address, s2_address;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic        s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [31:0] s1_writedata, s2_writedata;

  logic [1:0]  s1_wait_w, s2_wait_w, s1_rdv_w, s2_rdv_w;
  logic [31:0] s1_rd_w [2];
  logic [31:0] s2_rd_w [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mega_jsoc_onchip_mem_2p #(
      .DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(DEPTH), .OUTPUT_REG(g)
    ) u_dut (
      .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
      .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
      .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
      .s1_waitrequest(s1_wait_w[g]), .s1_readdata(s1_rd_w[g]), .s1_readdatavalid(s1_rdv_w[g]),
      .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
      .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
      .s2_waitrequest(s2_wait_w[g]), .s2_readdata(s2_rd_w[g]), .s2_readdatavalid(s2_rdv_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          inst;
    int          port;
    logic [31:0] data;
    int          due;
  } pend_t;

  logic [31:0] mmem [int];
  pend_t       pq [$];
  logic [31:0] hold_m [2][2];
  logic [31:0] last_str [2][2];
  int          last_win = 2;
  int          ecount = 0;

  initial begin
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        hold_m[k][p]   = '0;
        last_str[k][p] = '0;
      end
  end

  always @(negedge clk) begin : cmp
    bit          r1, r2, en, exp_v, w_wr;
    int          win, exp_p, a;
    logic [31:0] exp_d, d, w_d;
    logic [3:0]  w_be;
    pend_t       item;

    r1 = s1_chipselect && (s1_read || s1_write);
    r2 = s2_chipselect && (s2_read || s2_write);
    if (reset) begin
      pq.delete();
      last_win = 2;
      for (int k = 0; k < 2; k++)
        for (int p = 0; p < 2; p++) hold_m[k][p] = '0;
    end
    en  = clken && !reset_req && !reset;
    win = 0;
    if (en) begin
      if (r1 && r2)  win = (last_win == 2) ? 1 : 2;
      else if (r1)   win = 1;
      else if (r2)   win = 2;
    end

    for (int k = 0; k < 2; k++) begin
      check_bit($sformatf("k%0d s1_waitrequest", k), s1_wait_w[k], r1 && win != 1);
      check_bit($sformatf("k%0d s2_waitrequest", k), s2_wait_w[k], r2 && win != 2);
      exp_v = 1'b0;
      exp_p = 0;
      exp_d = '0;
      if (clken && !reset) begin
        for (int i = 0; i < pq.size(); i++) begin
          if (pq[i].inst == k) begin
            if (pq[i].due == ecount) begin
              exp_v = 1'b1;
              exp_p = pq[i].port;
              exp_d = pq[i].data;
              pq.delete(i);
            end
            break;
          end
        end
      end
      check_bit($sformatf("k%0d s1_readdatavalid", k), s1_rdv_w[k], exp_v && exp_p == 1);
      check_bit($sformatf("k%0d s2_readdatavalid", k), s2_rdv_w[k], exp_v && exp_p == 2);
      if (exp_v) hold_m[k][exp_p-1] = exp_d;
      check($sformatf("k%0d s1_readdata", k), s1_rd_w[k], hold_m[k][0]);
      check($sformatf("k%0d s2_readdata", k), s2_rd_w[k], hold_m[k][1]);
      if (s1_rdv_w[k]) last_str[k][0] = s1_rd_w[k];
      if (s2_rdv_w[k]) last_str[k][1] = s2_rd_w[k];
    end

    if (win != 0) begin
      last_win = win;
      a    = (win == 1) ? int'(s1_address) : int'(s2_address);
      w_wr = (win == 1) ? s1_write : s2_write;
      w_d  = (win == 1) ? s1_writedata : s2_writedata;
      w_be = (win == 1) ? s1_byteenable : s2_byteenable;
      if (w_wr) begin
        if (a < DEPTH) begin
          d = mmem.exists(a) ? mmem[a] : '0;
          for (int b = 0; b < 4; b++) if (w_be[b]) d[b*8 +: 8] = w_d[b*8 +: 8];
          mmem[a] = d;
        end
      end else begin
        d = (a < DEPTH && mmem.exists(a)) ? mmem[a] : '0;
        for (int k = 0; k < 2; k++) begin
          item.inst = k;
          item.port = win;
          item.data = d;
          item.due  = ecount + k + 1;
          pq.push_back(item);
        end
      end
    end
    if (clken) ecount++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0;
  endtask

  task automatic set_port(input int p, input bit rd, input bit wr, input logic [9:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    if (p == 1) begin
      s1_chipselect = 1; s1_read = rd; s1_write = wr;
      s1_address = a; s1_writedata = d; s1_byteenable = be;
    end else begin
      s2_chipselect = 1; s2_read = rd; s2_write = wr;
      s2_address = a; s2_writedata = d; s2_byteenable = be;
    end
  endtask

  task automatic wr(input int p, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    idle();
    set_port(p, 1'b0, 1'b1, a, d, be);
    tick(1);
  endtask

  task automatic rd(input int p, input logic [9:0] a);
    idle();
    set_port(p, 1'b1, 1'b0, a, '0, '0);
    tick(1);
  endtask

  task automatic nop(input int n);
    idle();
    tick(n);
  endtask

  task automatic check_last(input string name, input int p, input logic [31:0] exp);
    for (int k = 0; k < 2; k++)
      check($sformatf("%s k%0d s%0d data", name, k, p), last_str[k][p-1], exp);
  endtask

  task automatic check_reset_outputs(input string name);
    for (int k = 0; k < 2; k++) begin
      check_bit($sformatf("%s k%0d s1_rdv", name, k), s1_rdv_w[k], 1'b0);
      check_bit($sformatf("%s k%0d s2_rdv", name, k), s2_rdv_w[k], 1'b0);
      check($sformatf("%s k%0d s1_rdata", name, k), s1_rd_w[k], 32'h0);
      check($sformatf("%s k%0d s2_rdata", name, k), s2_rd_w[k], 32'h0);
    end
  endtask

  initial begin
    reset = 1; clken = 1; reset_req = 0;
    s1_address = '0; s2_address = '0; s1_writedata = '0; s2_writedata = '0;
    s1_byteenable = '0; s2_byteenable = '0;
    idle();
    #1;
    set_port(1, 1'b1, 1'b0, 10'd5, '0, '0);
    tick(2);
    check_reset_outputs("por");
    reset = 0;
    nop(1);

    // single-port write then read, plus a known word at address 0
    wr(1, 10'd5, 32'hDEADBEEF, 4'hF);
    wr(1, 10'd0, 32'h00000A0A, 4'hF);
    rd(1, 10'd5);
    nop(3);
    check_last("single", 1, 32'hDEADBEEF);

    // byte enables
    wr(1, 10'd7, 32'h11223344, 4'hF);
    wr(2, 10'd7, 32'hAABBCCDD, 4'h5);
    rd(1, 10'd7);
    nop(3);
    check_last("byteen", 1, 32'h11BB33DD);

    // continuous contention; s2 granted last so s1 wins first
    wr(1, 10'd1, 32'h11110001, 4'hF);
    wr(2, 10'd2, 32'h22220002, 4'hF);
    idle();
    set_port(1, 1'b1, 1'b0, 10'd1, '0, '0);
    set_port(2, 1'b1, 1'b0, 10'd2, '0, '0);
    for (int i = 0; i < 8; i++) begin
      #3;
      check($sformatf("rr%0d s1_wait", i), 32'(s1_wait_w[0]), 32'(i % 2));
      check($sformatf("rr%0d s2_wait", i), 32'(s2_wait_w[0]), 32'((i + 1) % 2));
      tick(1);
    end
    nop(3);
    check_last("rr", 1, 32'h11110001);
    check_last("rr", 2, 32'h22220002);

    // clken low for 3 cycles with a read in flight
    rd(1, 10'd5);
    clken = 0;
    set_port(2, 1'b1, 1'b0, 10'd7, '0, '0);
    tick(3);
    clken = 1;
    nop(3);
    check_last("clken", 1, 32'hDEADBEEF);

    // boundary around DEPTH
    wr(1, 10'd999, 32'h99990999, 4'hF);
    wr(2, 10'd1000, 32'hFFFFFFFF, 4'hF);
    rd(2, 10'd999);
    rd(1, 10'd0);
    nop(3);
    check_last("bound999", 2, 32'h99990999);
    check_last("alias0", 1, 32'h00000A0A);
    rd(1, 10'd1000);
    nop(3);
    check_last("oor", 1, 32'h0);

    // reset with reads in flight; s1 granted last, yet s1 must win after reset
    rd(2, 10'd7);
    rd(1, 10'd5);
    reset = 1;
    idle();
    #3;
    check_reset_outputs("midrst");
    tick(1);
    reset = 0;
    set_port(1, 1'b1, 1'b0, 10'd1, '0, '0);
    set_port(2, 1'b1, 1'b0, 10'd2, '0, '0);
    #3;
    check("postrst s1_wait", 32'(s1_wait_w[1]), 32'h0);
    check("postrst s2_wait", 32'(s2_wait_w[1]), 32'h1);
    tick(1);
    nop(3);
    check_last("postrst", 1, 32'h11110001);

    // reset_req blocks a pending write
    idle();
    reset_req = 1;
    set_port(1, 1'b0, 1'b1, 10'd5, 32'h0BADF00D, 4'hF);
    for (int i = 0; i < 3; i++) begin
      #3;
      check($sformatf("rreq%0d s1_wait", i), 32'(s1_wait_w[0]), 32'h1);
      tick(1);
    end
    reset_req = 0;
    rd(1, 10'd5);
    nop(3);
    check_last("rreq", 1, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
